// File: rtl/mux_4_1_rr.sv
// Round-robin 4-to-1 stream merger with a registered, source-tagged output.
// The rotating priority pointer moves just past the last served channel.
module mux_4_1_rr #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   input  logic [DATA_W-1:0] din2,
   input  logic [DATA_W-1:0] din3,
   input  logic              valid0,
   input  logic              valid1,
   input  logic              valid2,
   input  logic              valid3,
   output logic              ready0,
   output logic              ready1,
   output logic              ready2,
   output logic              ready3,
   output logic [DATA_W-1:0] dout,
   output logic [1:0]        dout_sel,
   output logic              dout_valid,
   input  logic              dout_ready
);

   logic [DATA_W-1:0] din_arr [4];
   logic [3:0]        valid_vec;
   logic [3:0]        ready_vec;

   logic [1:0]        ptr_q, ptr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [1:0]        sel_q, sel_d;
   logic              vld_q, vld_d;

   logic              free;
   logic [1:0]        grant;
   logic              grant_vld;
   logic [1:0]        scan_idx;

   assign din_arr[0] = din0;
   assign din_arr[1] = din1;
   assign din_arr[2] = din2;
   assign din_arr[3] = din3;
   assign valid_vec  = {valid3, valid2, valid1, valid0};

   assign free = !vld_q || dout_ready;

   // Scan from the farthest offset down so the nearest valid channel to ptr wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      scan_idx  = '0;
      for (int k = 3; k >= 0; k--) begin
         scan_idx = ptr_q + 2'(k);
         if (valid_vec[scan_idx]) begin
            grant     = scan_idx;
            grant_vld = 1'b1;
         end
      end
   end

   // Readies are gated by rst_n so they drop immediately while reset is held.
   always_comb begin
      ready_vec = '0;
      if (rst_n && free && grant_vld) begin
         ready_vec[grant] = 1'b1;
      end
   end

   assign ready0 = ready_vec[0];
   assign ready1 = ready_vec[1];
   assign ready2 = ready_vec[2];
   assign ready3 = ready_vec[3];

   always_comb begin
      ptr_d  = ptr_q;
      dout_d = dout_q;
      sel_d  = sel_q;
      vld_d  = vld_q;
      if (free) begin
         if (grant_vld) begin
            dout_d = din_arr[grant];
            sel_d  = grant;
            vld_d  = 1'b1;
            ptr_d  = grant + 2'd1;
         end else begin
            vld_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q  <= '0;
         dout_q <= '0;
         sel_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         dout_q <= dout_d;
         sel_q  <= sel_d;
         vld_q  <= vld_d;
      end
   end

   assign dout       = dout_q;
   assign dout_sel   = sel_q;
   assign dout_valid = vld_q;

endmodule

// File: tb/tb_mux_4_1_rr.sv
// Bench for mux_4_1_rr: directed scenarios with literal expectations, plus a
// cycle-by-cycle comparison against a transaction-level model of the merger.
module tb_mux_4_1_rr;

   logic       clk;
   logic       rst_n;
   logic [7:0] din0, din1, din2, din3;
   logic       valid0, valid1, valid2, valid3;
   logic       ready0, ready1, ready2, ready3;
   logic [7:0] dout;
   logic [1:0] dout_sel;
   logic       dout_valid;
   logic       dout_ready;

   int checks = 0;
   int errors = 0;

   mux_4_1_rr #(.DATA_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din0       (din0),
      .din1       (din1),
      .din2       (din2),
      .din3       (din3),
      .valid0     (valid0),
      .valid1     (valid1),
      .valid2     (valid2),
      .valid3     (valid3),
      .ready0     (ready0),
      .ready1     (ready1),
      .ready2     (ready2),
      .ready3     (ready3),
      .dout       (dout),
      .dout_sel   (dout_sel),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: an output slot, a pointer and a round-robin pick.
   int m_dout, m_sel, m_valid, m_ptr;

   function automatic int pick(input int ptr, input logic [3:0] v);
      for (int k = 0; k < 4; k++) begin
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready();
      logic [3:0] r;
      int g;
      r = '0;
      g = pick(m_ptr, {valid3, valid2, valid1, valid0});
      if (rst_n && (m_valid == 0 || dout_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   initial begin
      m_dout = 0; m_sel = 0; m_valid = 0; m_ptr = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_dout = 0; m_sel = 0; m_valid = 0; m_ptr = 0;
         end else if (m_valid == 0 || dout_ready) begin
            int g;
            int d [4];
            d[0] = din0; d[1] = din1; d[2] = din2; d[3] = din3;
            g = pick(m_ptr, {valid3, valid2, valid1, valid0});
            if (g >= 0) begin
               m_dout = d[g]; m_sel = g; m_valid = 1; m_ptr = (g + 1) % 4;
            end else begin
               m_valid = 0;
            end
         end
      end
   end

   // Continuous comparison at the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         check("model dout", 32'(dout), 32'(m_dout));
         check("model dout_sel", 32'(dout_sel), 32'(m_sel));
         check("model dout_valid", 32'(dout_valid), 32'(m_valid));
         check("model ready", 32'({ready3, ready2, ready1, ready0}), 32'(exp_ready()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_valids(input logic [3:0] v);
      {valid3, valid2, valid1, valid0} = v;
   endtask

   initial begin
      rst_n = 1'b0;
      din0 = 8'h10; din1 = 8'h11; din2 = 8'h12; din3 = 8'h13;
      set_valids(4'b1111);
      dout_ready = 1'b1;

      // Reset values with all channels requesting.
      repeat (3) tick();
      check("reset dout", 32'(dout), 32'h0);
      check("reset dout_sel", 32'(dout_sel), 32'h0);
      check("reset dout_valid", 32'(dout_valid), 32'h0);
      check("reset readies", 32'({ready3, ready2, ready1, ready0}), 32'h0);

      // Release; channel 0 has first priority, then full rotation.
      rst_n = 1'b1;
      #1;
      check("first grant", 32'({ready3, ready2, ready1, ready0}), 32'b0001);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rotation sel", 32'(dout_sel), 32'(i % 4));
         check("rotation data", 32'(dout), 32'(8'h10 + i % 4));
         check("rotation valid", 32'(dout_valid), 32'h1);
      end

      // Back-pressure: last word (channel 3, 8'h13) must hold.
      dout_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall readies", 32'({ready3, ready2, ready1, ready0}), 32'h0);
         tick();
         check("stall sel", 32'(dout_sel), 32'h3);
         check("stall data", 32'(dout), 32'h13);
         check("stall valid", 32'(dout_valid), 32'h1);
      end
      dout_ready = 1'b1;
      #1;
      check("unstall grant", 32'({ready3, ready2, ready1, ready0}), 32'b0001);
      tick();
      check("unstall sel", 32'(dout_sel), 32'h0);
      check("unstall data", 32'(dout), 32'h10);

      // Single channel 2.
      set_valids(4'b0100);
      din2 = 8'hA5;
      #1;
      check("single ready2", 32'({ready3, ready2, ready1, ready0}), 32'b0100);
      tick();
      check("single data", 32'(dout), 32'hA5);
      check("single sel", 32'(dout_sel), 32'h2);
      check("single valid", 32'(dout_valid), 32'h1);
      set_valids(4'b0000);
      tick();
      check("drain valid", 32'(dout_valid), 32'h0);
      check("drain sel hold", 32'(dout_sel), 32'h2);

      // Wrap-around: ptr is 3, channels 1 and 2 request; scan 3,0,1,2.
      din1 = 8'h21; din2 = 8'h22;
      set_valids(4'b0110);
      #1;
      check("wrap grant1", 32'({ready3, ready2, ready1, ready0}), 32'b0010);
      tick();
      check("wrap sel1", 32'(dout_sel), 32'h1);
      check("wrap data1", 32'(dout), 32'h21);
      #1;
      check("wrap grant2", 32'({ready3, ready2, ready1, ready0}), 32'b0100);
      tick();
      check("wrap sel2", 32'(dout_sel), 32'h2);
      check("wrap data2", 32'(dout), 32'h22);

      // Reset mid-stream, asserted between edges.
      din1 = 8'h11; din2 = 8'h12;
      set_valids(4'b1111);
      repeat (3) tick();
      check("pre-reset valid", 32'(dout_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async dout", 32'(dout), 32'h0);
      check("async sel", 32'(dout_sel), 32'h0);
      check("async valid", 32'(dout_valid), 32'h0);
      check("async readies", 32'({ready3, ready2, ready1, ready0}), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("restart sel0", 32'(dout_sel), 32'h0);
      check("restart data0", 32'(dout), 32'h10);
      tick();
      check("restart sel1", 32'(dout_sel), 32'h1);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
